// File: rtl/cic_ctrl.sv
// CIC decimator sequencer: flush, fill and run control with clock-enable/strobe outputs.
// Latency: every output is registered; int_ce/dec_stb follow the qualifying din_valid by one cycle.
// Backpressure: none on the sample stream; cfg_ready is low while flushing or filling.
// Optional CIC_CTRL_DROP_EN: adds dout_ready input and a saturating drop_cnt output.
module cic_ctrl #(
    parameter int STAGES        = 3,
    parameter int DIFF_DELAY    = 1,
    parameter int RATIO_WIDTH   = 8,
    parameter int DEFAULT_RATIO = 8,
    parameter int MIN_RATIO     = 2,
    parameter int COMB_LAT      = 3
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   din_valid,
    input  logic [RATIO_WIDTH-1:0] cfg_ratio,
    input  logic                   cfg_valid,
`ifdef CIC_CTRL_DROP_EN
    input  logic                   dout_ready,
    output logic [15:0]            drop_cnt,
`endif
    output logic                   cfg_ready,
    output logic                   cfg_err,
    output logic [RATIO_WIDTH-1:0] active_ratio,
    output logic                   cic_rst,
    output logic                   int_ce,
    output logic                   dec_stb,
    output logic                   dout_valid,
    output logic [1:0]             state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam int FLUSH_LEN = STAGES + 2;
    localparam int FCW       = $clog2(FLUSH_LEN + 1);
    localparam int FILL_STB  = STAGES * DIFF_DELAY;
    localparam int SCW       = $clog2(FILL_STB + 1);

    logic [1:0]             state_nx;
    logic [FCW-1:0]         flush_cnt;
    logic [SCW-1:0]         stb_cnt;
    logic [RATIO_WIDTH-1:0] phase;
    logic [COMB_LAT-1:0]    dly;

    logic                   cfg_acc;
    logic                   cfg_legal;
    logic                   phase_wrap;
    logic                   counting;
    logic                   int_ce_nx;
    logic                   dec_stb_nx;
    logic                   cic_rst_nx;
    logic                   cfg_ready_nx;
    logic                   cfg_err_nx;
    logic [COMB_LAT-1:0]    dly_nx;

    assign cfg_acc    = cfg_valid && cfg_ready;
    assign cfg_legal  = cfg_ratio >= RATIO_WIDTH'(MIN_RATIO);
    assign phase_wrap = (phase == active_ratio - 1'b1);
    assign dout_valid = dly[COMB_LAT-1];

    // Next-state: en=0 always returns to IDLE; a cfg accept in IDLE holds IDLE for that cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (cfg_acc)  state_nx = S_IDLE;
                else if (en)  state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (!en)                                    state_nx = S_IDLE;
                else if (flush_cnt == FCW'(FLUSH_LEN - 1))  state_nx = S_FILL;
            end
            S_FILL: begin
                if (!en)                                          state_nx = S_IDLE;
                else if (dec_stb && stb_cnt == SCW'(FILL_STB - 1)) state_nx = S_RUN;
            end
            default: begin
                if (!en)                       state_nx = S_IDLE;
                else if (cfg_acc && cfg_legal) state_nx = S_FLUSH;
            end
        endcase
    end

    // Output decode: values the output registers take on the next edge.
    always_comb begin
        counting     = (state == S_FILL || state == S_RUN) &&
                       (state_nx == S_FILL || state_nx == S_RUN);
        int_ce_nx    = counting && din_valid;
        dec_stb_nx   = counting && din_valid && phase_wrap;
        cic_rst_nx   = (state_nx == S_IDLE) || (state_nx == S_FLUSH);
        cfg_ready_nx = (state_nx == S_IDLE) || (state_nx == S_RUN);
        cfg_err_nx   = cfg_acc && !cfg_legal;
        // Strobes only enter the comb delay line while staying in RUN; any exit empties it.
        dly_nx       = '0;
        if (state == S_RUN && state_nx == S_RUN)
            dly_nx = (dly << 1) | COMB_LAT'(dec_stb);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= S_IDLE;
            active_ratio <= RATIO_WIDTH'(DEFAULT_RATIO);
            cic_rst      <= 1'b1;
            cfg_ready    <= 1'b1;
            cfg_err      <= 1'b0;
            int_ce       <= 1'b0;
            dec_stb      <= 1'b0;
            dly          <= '0;
            flush_cnt    <= '0;
            stb_cnt      <= '0;
            phase        <= '0;
        end else begin
            state     <= state_nx;
            cic_rst   <= cic_rst_nx;
            cfg_ready <= cfg_ready_nx;
            cfg_err   <= cfg_err_nx;
            int_ce    <= int_ce_nx;
            dec_stb   <= dec_stb_nx;
            dly       <= dly_nx;

            if (cfg_acc && cfg_legal)
                active_ratio <= cfg_ratio;

            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;

            if (state != S_FILL)
                stb_cnt <= '0;
            else if (dec_stb)
                stb_cnt <= stb_cnt + 1'b1;

            // Ratio only changes through FLUSH/IDLE, so the phase never sees a mid-period change.
            if (!counting)
                phase <= '0;
            else if (din_valid)
                phase <= phase_wrap ? '0 : phase + 1'b1;
        end
    end

`ifdef CIC_CTRL_DROP_EN
    // Count output samples refused downstream; restart the count on each flush.
    always_ff @(posedge clk_in) begin
        if (rst)
            drop_cnt <= '0;
        else if (state_nx == S_FLUSH && state != S_FLUSH)
            drop_cnt <= '0;
        else if (dout_valid && !dout_ready && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_cic_ctrl.sv
// Bench for cic_ctrl: directed test-plan sequence with literal checks, then random stimulus,
// all outputs compared every cycle against a sample-count / event-time model.
module tb_cic_ctrl;

    localparam int STAGES        = 3;
    localparam int DIFF_DELAY    = 1;
    localparam int RW            = 8;
    localparam int DEFAULT_RATIO = 8;
    localparam int MIN_RATIO     = 2;
    localparam int COMB_LAT      = 3;
    localparam int N_RAND        = 30000;

    logic          clk_in = 1'b0;
    logic          rst, en, din_valid, cfg_valid, dout_ready;
    logic [RW-1:0] cfg_ratio;
    logic          cfg_ready, cfg_err, cic_rst, int_ce, dec_stb, dout_valid;
    logic [RW-1:0] active_ratio;
    logic [1:0]    state;
    logic [15:0]   drop_cnt;

    always #5 clk_in = ~clk_in;

    cic_ctrl #(
        .STAGES(STAGES), .DIFF_DELAY(DIFF_DELAY), .RATIO_WIDTH(RW),
        .DEFAULT_RATIO(DEFAULT_RATIO), .MIN_RATIO(MIN_RATIO), .COMB_LAT(COMB_LAT)
    ) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .din_valid(din_valid),
        .cfg_ratio(cfg_ratio), .cfg_valid(cfg_valid),
`ifdef CIC_CTRL_DROP_EN
        .dout_ready(dout_ready), .drop_cnt(drop_cnt),
`endif
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .active_ratio(active_ratio),
        .cic_rst(cic_rst), .int_ce(int_ce), .dec_stb(dec_stb),
        .dout_valid(dout_valid), .state(state)
    );

`ifndef CIC_CTRL_DROP_EN
    assign drop_cnt = 16'd0;
`endif

    int checks = 0;
    int errors = 0;
    int tcur   = 0;

    // Model: state name, cycles spent in FLUSH, samples since FILL entry, strobes seen in FILL,
    // and the absolute cycle numbers at which dout_valid is due.
    int m_state, m_flush_n, m_nsamp, m_fill_stb, m_ratio, m_drop;
    int pend[$];
    int e_state, e_cic_rst, e_int_ce, e_dec_stb, e_dv, e_rdy, e_err;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, tcur);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_flush_n = 0; m_nsamp = 0; m_fill_stb = 0;
        m_ratio = DEFAULT_RATIO; m_drop = 0;
        pend.delete();
        e_state = 0; e_cic_rst = 1; e_int_ce = 0; e_dec_stb = 0;
        e_dv = 0; e_rdy = 1; e_err = 0;
    endtask

    function automatic bit busy(input int s);
        return (s == 2) || (s == 3);
    endfunction

    // Advance the model one clock using the inputs currently driven.
    task automatic model_step();
        int  nxt;
        bit  acc, legal, cnt, ce, stb, dv;
        if (rst) begin
            model_reset();
        end else begin
            acc   = cfg_valid && (m_state == 0 || m_state == 3);
            legal = int'(cfg_ratio) >= MIN_RATIO;
            nxt   = m_state;
            case (m_state)
                0: if (!acc && en) nxt = 1;
                1: if (!en) nxt = 0; else if (m_flush_n == STAGES + 2) nxt = 2;
                2: if (!en) nxt = 0;
                   else if (e_dec_stb && m_fill_stb + 1 == STAGES * DIFF_DELAY) nxt = 3;
                default: if (!en) nxt = 0; else if (acc && legal) nxt = 1;
            endcase

            cnt = busy(m_state) && busy(nxt);
            ce  = cnt && din_valid;
            stb = ce && ((m_nsamp + 1) % m_ratio == 0);
            if (cnt) begin
                if (din_valid) m_nsamp++;
            end else begin
                m_nsamp = 0;
            end

            if (m_state == 2) begin
                if (e_dec_stb) m_fill_stb++;
            end else begin
                m_fill_stb = 0;
            end

            if (m_state == 3 && nxt == 3 && e_dec_stb) pend.push_back(tcur + COMB_LAT);
            if (nxt != 3) pend.delete();
            dv = 0;
            if (pend.size() > 0 && pend[0] == tcur + 1) begin
                dv = 1;
                void'(pend.pop_front());
            end

            if (nxt == 1 && m_state != 1) m_drop = 0;
            else if (e_dv && !dout_ready && m_drop < 65535) m_drop++;

            m_flush_n = (nxt == 1) ? ((m_state == 1) ? m_flush_n + 1 : 1) : 0;
            if (acc && legal) m_ratio = cfg_ratio;

            e_err     = acc && !legal;
            e_state   = nxt;
            e_cic_rst = (nxt == 0 || nxt == 1);
            e_rdy     = (nxt == 0 || nxt == 3);
            e_int_ce  = ce;
            e_dec_stb = stb;
            e_dv      = dv;
            m_state   = nxt;
        end
        tcur++;
    endtask

    task automatic compare();
        chk("state", state, e_state);
        chk("cic_rst", cic_rst, e_cic_rst);
        chk("cfg_ready", cfg_ready, e_rdy);
        chk("cfg_err", cfg_err, e_err);
        chk("active_ratio", active_ratio, m_ratio);
        chk("int_ce", int_ce, e_int_ce);
        chk("dec_stb", dec_stb, e_dec_stb);
        chk("dout_valid", dout_valid, e_dv);
`ifdef CIC_CTRL_DROP_EN
        chk("drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    // Hand-derived expectations for the directed sequence (n = cycles since reset release).
    task automatic literal(input int n);
        case (n)
            0:   begin chk("L rst state", state, 0); chk("L rst cic_rst", cic_rst, 1);
                       chk("L rst cfg_ready", cfg_ready, 1); chk("L rst ratio", active_ratio, 8);
                       chk("L rst int_ce", int_ce, 0); chk("L rst dout_valid", dout_valid, 0); end
            1:   chk("L flush start", state, 1);
            5:   chk("L flush end", state, 1);
            6:   begin chk("L fill", state, 2); chk("L fill cic_rst", cic_rst, 0); end
            13:  chk("L no stb 13", dec_stb, 0);
            14:  chk("L stb 14", dec_stb, 1);
            22:  chk("L stb 22", dec_stb, 1);
            30:  chk("L fill 30", state, 2);
            31:  chk("L run 31", state, 3);
            38:  begin chk("L stb 38", dec_stb, 1); chk("L dv 38", dout_valid, 0); end
            40:  chk("L dv 40", dout_valid, 0);
            41:  chk("L first dv 41", dout_valid, 1);
            43:  begin chk("L err pulse", cfg_err, 1); chk("L err ratio", active_ratio, 8);
                       chk("L err state", state, 3); end
            44:  chk("L err clear", cfg_err, 0);
            46:  begin chk("L cfg flush", state, 1); chk("L cfg ratio", active_ratio, 4);
                       chk("L cfg dv", dout_valid, 0); chk("L cfg rdy", cfg_ready, 0); end
            55:  chk("L r4 stb 55", dec_stb, 1);
            58:  chk("L r4 no stb 58", dec_stb, 0);
            59:  chk("L r4 stb 59", dec_stb, 1);
`ifdef CIC_CTRL_DROP_EN
            88:  chk("L drop 5", drop_cnt, 5);
            91:  chk("L drop clr", drop_cnt, 0);
`endif
            101: begin chk("L en0 idle", state, 0); chk("L en0 cic_rst", cic_rst, 1);
                       chk("L en0 dv", dout_valid, 0); end
            132: chk("L run 132", state, 3);
            136: begin chk("L mid rst state", state, 0); chk("L mid rst ratio", active_ratio, 8);
                       chk("L mid rst cic_rst", cic_rst, 1); chk("L mid rst rdy", cfg_ready, 1);
                       chk("L mid rst stb", dec_stb, 0); chk("L mid rst ce", int_ce, 0); end
            default: ;
        endcase
    endtask

    initial begin
        int mode;
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; cfg_valid = 1'b0;
        cfg_ratio = '0; dout_ready = 1'b1;
        model_reset();

        repeat (3) begin
            @(negedge clk_in);
            compare();
            model_step();
        end

        for (int n = 0; n < 140; n++) begin
            @(negedge clk_in);
            compare();
            literal(n);
            rst        = (n == 135);
            en         = (n != 100);
            din_valid  = 1'b1;
            cfg_valid  = (n == 42) || (n == 45) || (n == 90);
            cfg_ratio  = (n == 42) ? 8'd1 : (n == 45) ? 8'd4 : 8'd8;
            dout_ready = !(n >= 68 && n <= 86);
            model_step();
        end

        mode = 0;
        for (int i = 0; i < N_RAND; i++) begin
            @(negedge clk_in);
            compare();
            if (i % 2000 == 0) mode = $urandom_range(0, 2);
            rst        = ($urandom_range(0, 999) < 2);
            en         = ($urandom_range(0, 99) < 98);
            din_valid  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            cfg_valid  = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 5))
                0: cfg_ratio = 8'd0;
                1: cfg_ratio = 8'd1;
                2: cfg_ratio = 8'd2;
                3: cfg_ratio = 8'($urandom_range(2, 12));
                4: cfg_ratio = 8'($urandom_range(3, 6));
                default: cfg_ratio = 8'($urandom_range(0, 40));
            endcase
            dout_ready = ($urandom_range(0, 3) != 0);
            model_step();
        end

        @(negedge clk_in);
        compare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_ctrl.md
Name: cic_ctrl

Overview:
Sequencing controller for the CIC decimator datapath (integrator chain, decimation, comb chain) using single-clock clock-enable/strobe signalling instead of a divided clock. It holds a runtime-programmable decimation ratio and flushes the datapath on start and on every ratio change. It generates the integrator enable and the decimation strobe, and suppresses output-valid until the comb chain has settled. It sits between the ADC sample stream and the CIC datapath, with a cfg handshake toward the control plane.

Parameters:
STAGES, 3, number of integrator/comb stages (M); must be >= 1
DIFF_DELAY, 1, comb differential delay (N)
RATIO_WIDTH, 8, width of decimation ratio field
DEFAULT_RATIO, 8, ratio loaded at reset
MIN_RATIO, 2, smallest legal ratio
COMB_LAT, 3, clk_in cycles from dec_stb to valid comb output

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  run enable
din_valid  input  1  ADC sample valid; may be high every cycle
cfg_ratio  input  RATIO_WIDTH  requested decimation ratio R
cfg_valid  input  1  cfg request
cfg_ready  output  1  cfg can be accepted
cfg_err  output  1  one-cycle pulse: rejected ratio
active_ratio  output  RATIO_WIDTH  ratio in use
cic_rst  output  1  flush/reset to integrator and comb
int_ce  output  1  integrator clock enable
dec_stb  output  1  one-cycle decimation strobe to comb
dout_valid  output  1  qualified CIC output valid
state  output  2  0 IDLE, 1 FLUSH, 2 FILL, 3 RUN

Behaviour:
- Reset values: state=IDLE, active_ratio=DEFAULT_RATIO, cic_rst=1, cfg_ready=1, and int_ce, dec_stb, dout_valid and cfg_err all 0. The phase counter, strobe counter and dout_valid delay line are cleared.
- All outputs are registered.
- IDLE:
  - cic_rst=1.
  - en=1 moves to FLUSH on the next cycle.
- FLUSH:
  - cic_rst=1 for exactly STAGES+2 cycles, then FILL.
  - The phase counter is cleared on exit.
- FILL:
  - cic_rst=0.
  - int_ce=din_valid.
  - The phase counter increments on each din_valid and wraps from active_ratio-1 to 0.
  - dec_stb=1 on the cycle after the din_valid that wraps the counter.
  - The strobe counter counts dec_stb. After STAGES*DIFF_DELAY strobes, move to RUN.
  - dout_valid is held at 0.
- RUN:
  - int_ce and dec_stb behave as in FILL.
  - dout_valid equals dec_stb delayed by exactly COMB_LAT cycles through a shift register.
- Leaving RUN or FILL:
  - en=0 in FLUSH, FILL or RUN moves to IDLE on the next cycle.
  - The delay line clears, so no dout_valid appears after the IDLE entry cycle.
- cfg handshake:
  - cfg_ready=1 in IDLE and RUN; 0 in FLUSH and FILL.
  - Acceptance occurs when cfg_valid && cfg_ready.
  - Illegal ratio (< MIN_RATIO): cfg_err pulses one cycle, active_ratio is unchanged, and the state is unchanged.
  - Legal ratio accepted in IDLE: active_ratio is latched and the state stays IDLE.
  - Legal ratio accepted in RUN: active_ratio is latched, the state moves to FLUSH, and dout_valid drops immediately.
- Simultaneous legal cfg and en=0 in RUN: the ratio is latched and the next state is IDLE; en=0 has priority over FLUSH.
- Ratio change is never applied mid-decimation-period. Only the accept path above modifies active_ratio.
- Phase counter width is RATIO_WIDTH. The maximum ratio is 2^RATIO_WIDTH-1; no wrap issue arises.
- rst mid-operation: all state returns to reset values on the next edge regardless of state.

Optional Feature:
CIC_CTRL_DROP_EN
- Defined:
  - Adds input dout_ready and output drop_cnt[15:0].
  - When dout_valid=1 and dout_ready=0, drop_cnt increments and saturates at 0xFFFF.
  - drop_cnt clears on rst and on every FLUSH entry.
- Undefined: neither port exists and there is no counting logic.

Test Plan:
- Reset, en=1, din_valid always 1, defaults:
  - state: IDLE -> FLUSH for 5 cycles -> FILL.
  - dec_stb every 8 cycles.
  - RUN after 3 strobes; first dout_valid 3 cycles after the 4th strobe.
- In RUN, cfg_ratio=4 with cfg_valid=1:
  - cfg_ready high, active_ratio=4, state -> FLUSH, dout_valid=0 next cycle.
  - After refill, dec_stb period is 4 cycles.
- cfg_ratio=1 in RUN: cfg_err pulses once, active_ratio stays 8, state stays RUN, strobe period unchanged.
- din_valid toggling 1/0 with ratio 8: dec_stb every 16 cycles, int_ce mirrors din_valid.
- Edge cases:
  - en=0 in FILL: next state IDLE, cic_rst=1, no dout_valid.
  - rst asserted in RUN: all outputs at reset values next cycle.
- With CIC_CTRL_DROP_EN, dout_ready=0 for 5 output samples:
  - drop_cnt=5.
  - A subsequent cfg change clears it to 0 on FLUSH entry.
